// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
// Holds the FSM state enum, 10-bit header prefix and R/W encodings.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_ACK_H,
    ST_ADR2,
    ST_ACK_A,
    ST_PTR,
    ST_ACK_P,
    ST_WR,
    ST_ACK_W,
    ST_RD,
    ST_MACK,
    ST_WAIT_P
  } state_e;

  localparam logic [4:0] HDR10_PREFIX = 5'b11110;
  localparam logic       RW_WRITE     = 1'b0;
  localparam logic       RW_READ      = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioning: 2-flop sync, optional 3-sample majority filter
// (I2C_GLITCH_FILT_EN), edge and START/STOP detection.
// Ports: clk, rst, scl, sda in; scl_rise, scl_fall, start, stop, sda_s out.
module i2c_bus_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_c;
  logic       sda_c;
  logic       scl_p_q;
  logic       sda_p_q;

  // Idle bus is high on both lines, so everything resets to 1
  // and no edge is seen when reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_GLITCH_FILT_EN
  logic [1:0] scl_h_q;
  logic [1:0] sda_h_q;
  logic       scl_f_q;
  logic       sda_f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h_q <= 2'b11;
      sda_h_q <= 2'b11;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_sync_q[1]};
      sda_h_q <= {sda_h_q[0], sda_sync_q[1]};
      scl_f_q <= maj3(scl_sync_q[1], scl_h_q[0], scl_h_q[1]);
      sda_f_q <= maj3(sda_sync_q[1], sda_h_q[0], sda_h_q[1]);
    end
  end

  assign scl_c = scl_f_q;
  assign sda_c = sda_f_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_c;
      sda_p_q <= sda_c;
    end
  end

  assign scl_rise = scl_c & ~scl_p_q;
  assign scl_fall = ~scl_c & scl_p_q;
  // START/STOP need scl high on both sides of the sda edge.
  assign start = scl_c & scl_p_q & sda_p_q & ~sda_c;
  assign stop  = scl_c & scl_p_q & ~sda_p_q & sda_c;
  assign sda_s = sda_c;

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target with byte register bank, 7/10-bit address, auto-increment.
// Ports: clk, rst, scl, sda(inout), host_adr/we/wr_dat/rd_dat,
// busy, wr_strobe, wr_idx. Optional glitch filter: I2C_GLITCH_FILT_EN.
module i2c_target_regbank
  import i2c_pkg::*;
#(
  parameter int          ADDR_MODE = 10,
  parameter logic [9:0]  OWN_ADDR  = 10'h040,
  parameter int          DEPTH     = 16,
  parameter int          PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  input  logic [PTR_W-1:0] host_adr,
  input  logic             host_we,
  input  logic [7:0]       host_wr_dat,
  output logic [7:0]       host_rd_dat,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_idx
);

  if (!(ADDR_MODE == 7 || ADDR_MODE == 10)) begin : g_bad_mode
    $error("ADDR_MODE must be 7 or 10");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..256");
  end
  if ((1 << PTR_W) != DEPTH) begin : g_bad_ptrw
    $error("PTR_W must equal clog2(DEPTH)");
  end

  localparam bit MODE7 = (ADDR_MODE == 7);

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic sda_s;

  i2c_bus_cond u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_e           state_q,     state_d;
  logic [3:0]       bitcnt_q,    bitcnt_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic [6:0]       tx_q,        tx_d;
  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic             sda_oe_q,    sda_oe_d;
  logic             busy_q,      busy_d;
  logic             addr10_q,    addr10_d;
  logic             rw_q,        rw_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_idx_q,    wr_idx_d;

  logic [7:0] bank_q [DEPTH];
  logic [7:0] rd_byte;
  logic       i2c_we;
  logic       rx_bit;
  logic       byte_done;
  logic       hdr_pfx10;
  logic       hdr_rd10;
  logic       hdr_ok;

  assign rd_byte   = bank_q[ptr_q];
  assign rx_bit    = scl_rise && (bitcnt_q != 4'd8);
  assign byte_done = scl_fall && (bitcnt_q == 4'd8);

  // A read header in 10-bit mode is only valid after a full
  // write-addressing sequence (addressed10 still set).
  assign hdr_pfx10 = (shreg_q[7:1] == {HDR10_PREFIX, OWN_ADDR[9:8]});
  assign hdr_rd10  = !MODE7 && hdr_pfx10 &&
                     (shreg_q[0] == RW_READ) && addr10_q;
  assign hdr_ok    = MODE7 ? (shreg_q[7:1] == OWN_ADDR[6:0])
                           : (hdr_pfx10 &&
                              ((shreg_q[0] == RW_WRITE) || hdr_rd10));

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addr10_d    = addr10_q;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    i2c_we      = 1'b0;

    if (stop) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      addr10_d = 1'b0;
    end else if (start) begin
      state_d  = ST_HDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_HDR: begin
          if (rx_bit) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (byte_done) begin
            addr10_d = hdr_rd10;
            if (hdr_ok) begin
              state_d  = ST_ACK_H;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shreg_q[0];
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ACK_H: begin
          if (scl_fall) begin
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            if (rw_q == RW_READ) begin
              state_d  = ST_RD;
              tx_d     = rd_byte[6:0];
              sda_oe_d = ~rd_byte[7];
              ptr_d    = ptr_q + 1'b1;
            end else if (MODE7) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_ADR2;
            end
          end
        end
        ST_ADR2: begin
          if (rx_bit) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (byte_done) begin
            if (shreg_q == OWN_ADDR[7:0]) begin
              state_d  = ST_ACK_A;
              sda_oe_d = 1'b1;
              addr10_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ACK_A: begin
          if (scl_fall) begin
            state_d  = ST_PTR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
          end
        end
        ST_PTR: begin
          if (rx_bit) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (byte_done) begin
            state_d  = ST_ACK_P;
            sda_oe_d = 1'b1;
          end
        end
        ST_ACK_P: begin
          if (scl_fall) begin
            state_d  = ST_WR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            ptr_d    = shreg_q[PTR_W-1:0];
          end
        end
        ST_WR: begin
          if (rx_bit) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (byte_done) begin
            state_d  = ST_ACK_W;
            sda_oe_d = 1'b1;
          end
        end
        ST_ACK_W: begin
          if (scl_fall) begin
            state_d     = ST_WR;
            bitcnt_d    = 4'd0;
            sda_oe_d    = 1'b0;
            i2c_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_idx_d    = ptr_q;
            ptr_d       = ptr_q + 1'b1;
          end
        end
        ST_RD: begin
          if (rx_bit) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (byte_done) begin
            state_d  = ST_MACK;
            sda_oe_d = 1'b0;
          end else if (scl_fall && bitcnt_q != 4'd0) begin
            tx_d     = {tx_q[5:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
        ST_MACK: begin
          if (scl_rise && sda_s) begin
            state_d = ST_WAIT_P;
          end else if (scl_fall) begin
            state_d  = ST_RD;
            bitcnt_d = 4'd0;
            tx_d     = rd_byte[6:0];
            sda_oe_d = ~rd_byte[7];
            ptr_d    = ptr_q + 1'b1;
          end
        end
        ST_WAIT_P: ;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= 8'd0;
      tx_q        <= 7'd0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr10_q    <= 1'b0;
      rw_q        <= RW_WRITE;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addr10_q    <= addr10_d;
      rw_q        <= rw_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  // Host port wins a same-index collision with an I2C commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (host_we && host_adr == PTR_W'(i))
          bank_q[i] <= host_wr_dat;
        else if (i2c_we && ptr_q == PTR_W'(i))
          bank_q[i] <= shreg_q;
      end
    end
  end

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign host_rd_dat = bank_q[host_adr];
  assign busy        = busy_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_idx      = wr_idx_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: a 10-bit and a 7-bit
// target share one bus driven by a simple bit-banged master.
module tb_i2c_target_regbank;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic m_sda = 1'b1;

  wire sda;
  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  logic [3:0] h_adr  = '0;
  logic       h_we   = 1'b0;
  logic [7:0] h_dat  = '0;
  wire  [7:0] h_rd;
  wire        busy;
  wire        wrs;
  wire  [3:0] wri;

  logic [3:0] h7_adr = '0;
  logic       h7_we  = 1'b0;
  logic [7:0] h7_dat = '0;
  wire  [7:0] h7_rd;
  wire        busy7;
  wire        wrs7;
  wire  [3:0] wri7;

  i2c_target_regbank #(
    .ADDR_MODE (10),
    .OWN_ADDR  (10'h040),
    .DEPTH     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl_m),
    .sda         (sda),
    .host_adr    (h_adr),
    .host_we     (h_we),
    .host_wr_dat (h_dat),
    .host_rd_dat (h_rd),
    .busy        (busy),
    .wr_strobe   (wrs),
    .wr_idx      (wri)
  );

  i2c_target_regbank #(
    .ADDR_MODE (7),
    .OWN_ADDR  (10'h040),
    .DEPTH     (16)
  ) dut7 (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl_m),
    .sda         (sda),
    .host_adr    (h7_adr),
    .host_we     (h7_we),
    .host_wr_dat (h7_dat),
    .host_rd_dat (h7_rd),
    .busy        (busy7),
    .wr_strobe   (wrs7),
    .wr_idx      (wri7)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int         scnt = 0;
  logic [3:0] sidx [64];

  always @(negedge clk) begin
    if (wrs === 1'b1) begin
      sidx[scnt % 64] = wri;
      scnt = scnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    scl_m = 1'b1;
    q(Q);
    m_sda = 1'b0;
    q(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    q(2);
    m_sda = 1'b1;
    q(Q);
    scl_m = 1'b1;
    q(Q);
    m_sda = 1'b0;
    q(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    q(2);
    m_sda = 1'b0;
    q(Q);
    scl_m = 1'b1;
    q(Q);
    m_sda = 1'b1;
    q(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack,
                       input bit coll);
    for (int i = 7; i >= 0; i--) begin
      q(2);
      m_sda = b[i];
      q(Q);
      scl_m = 1'b1;
      q(2 * Q);
      scl_m = 1'b0;
    end
    q(2);
    m_sda = 1'b1;
    q(Q);
    scl_m = 1'b1;
    q(Q);
    ack = sda;
    q(Q);
    scl_m = 1'b0;
    if (coll) begin
      // The commit edge is the third posedge after scl falls.
      q(2);
      h7_adr = 4'd0;
      h7_dat = 8'h77;
      h7_we  = 1'b1;
      q(1);
      chk("coll strobe", wrs7, 1'b1);
      chk("coll idx", wri7, 4'd0);
      h7_we = 1'b0;
    end
  endtask

  task automatic wck(input string tag, input logic [7:0] b,
                     input logic exp);
    logic a;
    wbyte(b, a, 1'b0);
    chk(tag, a, exp);
  endtask

  task automatic rbyte(output logic [7:0] b, input logic ackbit);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q(2 + Q);
      scl_m = 1'b1;
      q(Q);
      b[i] = sda;
      q(Q);
      scl_m = 1'b0;
    end
    q(2);
    m_sda = ackbit;
    q(Q);
    scl_m = 1'b1;
    q(2 * Q);
    scl_m = 1'b0;
    q(2);
    m_sda = 1'b1;
  endtask

  task automatic hwrite(input logic [3:0] a, input logic [7:0] d);
    h_adr = a;
    h_dat = d;
    h_we  = 1'b1;
    q(1);
    h_we  = 1'b0;
  endtask

  task automatic hread(input string tag, input logic [3:0] a,
                       input logic [7:0] exp);
    h_adr = a;
    q(1);
    chk(tag, h_rd, exp);
  endtask

  task automatic hread7(input string tag, input logic [3:0] a,
                        input logic [7:0] exp);
    h7_adr = a;
    q(1);
    chk(tag, h7_rd, exp);
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    int         s0;

    q(3);
    rst = 1'b0;
    q(2);
    chk("rst busy", busy, 1'b0);
    chk("rst strobe", wrs, 1'b0);
    chk("rst idx", wri, 4'd0);
    chk("rst sda", sda, 1'b1);
    chk("rst state", dut.state_q, ST_IDLE);
    hread("rst bank0", 4'd0, 8'h00);
    hread("rst bank15", 4'd15, 8'h00);

    // 10-bit write
    s0 = scnt;
    i2c_start();
    wck("w10 ack F0", 8'hF0, 1'b0);
    wck("w10 ack 40", 8'h40, 1'b0);
    wck("w10 ack 03", 8'h03, 1'b0);
    wck("w10 ack AA", 8'hAA, 1'b0);
    wck("w10 ack 55", 8'h55, 1'b0);
    chk("w10 busy", busy, 1'b1);
    i2c_stop();
    chk("w10 busy off", busy, 1'b0);
    chk("w10 strobes", scnt - s0, 2);
    chk("w10 idx0", sidx[s0 % 64], 4'd3);
    chk("w10 idx1", sidx[(s0 + 1) % 64], 4'd4);
    hread("w10 bank3", 4'd3, 8'hAA);
    hread("w10 bank4", 4'd4, 8'h55);
    hread7("w10 no 7bit", 4'd3, 8'h00);

    // host write latency and read preset
    hwrite(4'd5, 8'hC3);
    chk("host next cyc", h_rd, 8'hC3);
    hwrite(4'd3, 8'hAA);
    hwrite(4'd4, 8'h55);

    // 10-bit read with repeated START
    i2c_start();
    wck("r10 ack F0", 8'hF0, 1'b0);
    wck("r10 ack 40", 8'h40, 1'b0);
    wck("r10 ack 03", 8'h03, 1'b0);
    i2c_rstart();
    wck("r10 ack F1", 8'hF1, 1'b0);
    rbyte(d, 1'b0);
    chk("r10 byte0", d, 8'hAA);
    rbyte(d, 1'b1);
    chk("r10 byte1", d, 8'h55);
    q(4);
    chk("r10 sda rel", sda, 1'b1);
    chk("r10 busy", busy, 1'b1);
    i2c_stop();
    chk("r10 busy off", busy, 1'b0);

    // wrong second address byte
    i2c_start();
    wck("wa ack F0", 8'hF0, 1'b0);
    wck("wa nack 41", 8'h41, 1'b1);
    q(2);
    chk("wa state", dut.state_q, ST_IDLE);
    chk("wa busy", busy, 1'b0);
    i2c_stop();
    hread("wa bank3", 4'd3, 8'hAA);
    hread("wa bank5", 4'd5, 8'hC3);

    // pointer wrap
    i2c_start();
    wck("wr ack F0", 8'hF0, 1'b0);
    wck("wr ack 40", 8'h40, 1'b0);
    wck("wr ack 0F", 8'h0F, 1'b0);
    wck("wr ack 11", 8'h11, 1'b0);
    wck("wr ack 22", 8'h22, 1'b0);
    i2c_stop();
    hread("wr bank15", 4'd15, 8'h11);
    hread("wr bank0", 4'd0, 8'h22);

    // 7-bit target
    i2c_start();
    wck("s7 ack 80", 8'h80, 1'b0);
    wck("s7 ack 00", 8'h00, 1'b0);
    wck("s7 ack 5A", 8'h5A, 1'b0);
    i2c_stop();
    hread7("s7 bank0", 4'd0, 8'h5A);
    hread("s7 no 10bit", 4'd0, 8'h22);

    // host/I2C collision on index 0
    i2c_start();
    wck("c7 ack 80", 8'h80, 1'b0);
    wck("c7 ack 00", 8'h00, 1'b0);
    wbyte(8'h5A, a, 1'b1);
    chk("c7 ack 5A", a, 1'b0);
    i2c_stop();
    hread7("c7 host wins", 4'd0, 8'h77);

    // reset in the 4th bit of a data byte
    i2c_start();
    wck("mr ack F0", 8'hF0, 1'b0);
    wck("mr ack 40", 8'h40, 1'b0);
    wck("mr ack 00", 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      q(2);
      m_sda = 1'b1;
      q(Q);
      scl_m = 1'b1;
      q(2 * Q);
      scl_m = 1'b0;
    end
    q(2);
    m_sda = 1'b1;
    q(Q);
    scl_m = 1'b1;
    q(Q);
    chk("mr busy pre", busy, 1'b1);
    rst = 1'b1;
    q(1);
    rst = 1'b0;
    chk("mr sda", sda, 1'b1);
    chk("mr busy", busy, 1'b0);
    chk("mr state", dut.state_q, ST_IDLE);
    hread("mr bank0", 4'd0, 8'h00);
    hread("mr bank15", 4'd15, 8'h00);
    hread7("mr bank7", 4'd0, 8'h00);
    q(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
